// File: rtl/count_sequencer.sv
// count_sequencer: run/pause/stop controller for the 8-bit display counter.
// A rate divider produces a one-cycle tick while running; ticks advance
// count from 0 up to a limit latched at launch, after which done is flagged.
module count_sequencer #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 8,
  parameter int RATE0 = 1,
  parameter int RATE1 = 4,
  parameter int RATE2 = 16,
  parameter int RATE3 = 64
) (
  input  logic             clk,
  input  logic             clear_b,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       rate_sel,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  // Divider reload values: a tick every RATEn cycles means counting RATEn-1 .. 0.
  localparam logic [DIV_W-1:0] RL0 = DIV_W'(RATE0 - 1);
  localparam logic [DIV_W-1:0] RL1 = DIV_W'(RATE1 - 1);
  localparam logic [DIV_W-1:0] RL2 = DIV_W'(RATE2 - 1);
  localparam logic [DIV_W-1:0] RL3 = DIV_W'(RATE3 - 1);

  state_t           st, st_nxt;
  logic [DIV_W-1:0] div_cnt, div_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic [WIDTH-1:0] limit_q, limit_nxt;
  logic [1:0]       rate_q, rate_nxt;
  logic             launch;
  logic             term;

  function automatic logic [DIV_W-1:0] reload(input logic [1:0] sel);
    case (sel)
      2'd0:    reload = RL0;
      2'd1:    reload = RL1;
      2'd2:    reload = RL2;
      default: reload = RL3;
    endcase
  endfunction

  // Launch from IDLE or DONE: start without stop (stop always wins).
  assign launch = ((st == S_IDLE) || (st == S_DONE)) && start && !stop;
  // Terminal tick: this advance reaches the latched limit.
  assign term   = tick && (count == (limit_q - WIDTH'(1)));
  assign state  = st;

  // State register.
  always_ff @(posedge clk) begin
    if (!clear_b) st <= S_IDLE;
    else          st <= st_nxt;
  end

  // Next-state logic; terminal beats stop beats continue while running.
  always_comb begin
    st_nxt = st;
    case (st)
      S_IDLE: begin
        if (launch) st_nxt = (limit != '0) ? S_RUN : S_DONE;
      end
      S_RUN: begin
        if (term)      st_nxt = S_DONE;
        else if (stop) st_nxt = S_PAUSE;
      end
      S_PAUSE: begin
        if (stop)       st_nxt = S_IDLE;
        else if (start) st_nxt = S_RUN;
      end
      S_DONE: begin
        if (stop)        st_nxt = S_IDLE;
        else if (launch) st_nxt = (limit != '0) ? S_RUN : S_DONE;
      end
      default: st_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state and divider.
  always_comb begin
    tick = (st == S_RUN) && (div_cnt == '0);
    busy = (st == S_RUN) || (st == S_PAUSE);
    done = (st == S_DONE);
  end

  // Datapath next values: latch on launch, advance/divide while running.
  always_comb begin
    count_nxt = count;
    div_nxt   = div_cnt;
    limit_nxt = limit_q;
    rate_nxt  = rate_q;
    if (launch) begin
      limit_nxt = limit;
      rate_nxt  = rate_sel;
      count_nxt = '0;
      div_nxt   = reload(rate_sel);
    end else if (st == S_RUN) begin
      if (tick) count_nxt = count + WIDTH'(1);
      // A pausing edge leaves the divider where it is so resume continues the phase.
      if (stop && !term) div_nxt = div_cnt;
      else if (tick)     div_nxt = reload(rate_q);
      else               div_nxt = div_cnt - DIV_W'(1);
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!clear_b) begin
      count   <= '0;
      div_cnt <= '0;
      limit_q <= '0;
      rate_q  <= '0;
    end else begin
      count   <= count_nxt;
      div_cnt <= div_nxt;
      limit_q <= limit_nxt;
      rate_q  <= rate_nxt;
    end
  end

endmodule

// File: tb/tb_count_sequencer.sv
// Scoreboard bench for count_sequencer: stimulus steps a phase-based
// reference model and queues the expected post-edge outputs; a monitor
// pops and compares one entry after every clock edge.
module tb_count_sequencer;

  logic       clk = 1'b0;
  logic       clear_b = 1'b0, start = 1'b0, stop = 1'b0;
  logic [1:0] rate_sel = 2'd0;
  logic [7:0] limit = 8'd0;
  logic [7:0] count;
  logic       tick, busy, done;
  logic [1:0] state;

  count_sequencer dut (
    .clk(clk), .clear_b(clear_b), .start(start), .stop(stop),
    .rate_sel(rate_sel), .limit(limit), .count(count), .tick(tick),
    .busy(busy), .done(done), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] st;
    logic [7:0] cnt;
    logic       tk, bz, dn;
    string      lbl;
  } exp_t;

  exp_t  sb[$];
  exp_t  mon_e;
  int    n_tests = 0, n_fail = 0;
  string lbl = "reset";

  // Reference model: mode name, run-phase (RUN cycles since last tick/launch).
  typedef enum {M_IDLE, M_RUN, M_PAUSE, M_DONE} mode_t;
  mode_t m_mode = M_IDLE;
  int    m_cnt = 0, m_phase = 0, m_lim = 0, m_rate = 1;
  int    rates[4] = '{1, 4, 16, 64};

  function automatic logic [1:0] mode_code(input mode_t m);
    case (m)
      M_IDLE:  return 2'b00;
      M_RUN:   return 2'b01;
      M_PAUSE: return 2'b10;
      default: return 2'b11;
    endcase
  endfunction

  task automatic model_step(input logic c, s, p, input logic [1:0] r, input logic [7:0] l);
    bit t;
    if (!c) begin
      m_mode = M_IDLE; m_cnt = 0; m_phase = 0; m_lim = 0; m_rate = 1;
      return;
    end
    case (m_mode)
      M_IDLE, M_DONE: begin
        if (m_mode == M_DONE && p) m_mode = M_IDLE;
        else if (s && !p) begin
          m_lim = l; m_rate = rates[r]; m_cnt = 0; m_phase = 0;
          m_mode = (l != 0) ? M_RUN : M_DONE;
        end
      end
      M_RUN: begin
        t = (m_phase == m_rate - 1);
        if (t) m_cnt = m_cnt + 1;
        if (t && m_cnt == m_lim) m_mode = M_DONE;
        else if (p) m_mode = M_PAUSE;
        else m_phase = t ? 0 : m_phase + 1;
      end
      default: begin
        if (p) m_mode = M_IDLE;
        else if (s) m_mode = M_RUN;
      end
    endcase
  endtask

  // Drive one cycle of inputs and queue what the outputs must be after the edge.
  task automatic cyc(input logic c, s, p, input logic [1:0] r, input logic [7:0] l);
    exp_t e;
    @(negedge clk);
    clear_b = c; start = s; stop = p; rate_sel = r; limit = l;
    model_step(c, s, p, r, l);
    e.st  = mode_code(m_mode);
    e.cnt = 8'(m_cnt);
    e.tk  = (m_mode == M_RUN) && (m_phase == m_rate - 1);
    e.bz  = (m_mode == M_RUN) || (m_mode == M_PAUSE);
    e.dn  = (m_mode == M_DONE);
    e.lbl = lbl;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, rate_sel, limit);
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      n_tests++;
      if (state !== mon_e.st || count !== mon_e.cnt || tick !== mon_e.tk ||
          busy !== mon_e.bz || done !== mon_e.dn) begin
        n_fail++;
        $display("FAIL %s: got st=%b cnt=%0d tick=%b busy=%b done=%b, want st=%b cnt=%0d tick=%b busy=%b done=%b",
                 mon_e.lbl, state, count, tick, busy, done,
                 mon_e.st, mon_e.cnt, mon_e.tk, mon_e.bz, mon_e.dn);
      end
    end
  end

  initial begin
    // Reset with start asserted.
    lbl = "reset";
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 2'd0, 8'd5);
    cyc(1'b1, 1'b0, 1'b0, 2'd0, 8'd5);

    // Basic run at rate 1.
    lbl = "basic";
    cyc(1'b1, 1'b1, 1'b0, 2'd0, 8'd5);
    idle(8);

    // Rate 4 with pause/resume.
    lbl = "pause";
    cyc(1'b1, 1'b1, 1'b0, 2'd1, 8'd3);
    for (int i = 0; i < 20 && m_cnt < 1; i++) idle(1);
    cyc(1'b1, 1'b0, 1'b1, 2'd1, 8'd3);
    idle(10);
    cyc(1'b1, 1'b1, 1'b0, 2'd0, 8'd9);
    idle(16);

    // Edge commands.
    lbl = "limit0";
    cyc(1'b1, 1'b1, 1'b0, 2'd0, 8'd0);
    idle(2);
    lbl = "done_stop";
    cyc(1'b1, 1'b0, 1'b1, 2'd0, 8'd0);
    lbl = "idle_start_stop";
    cyc(1'b1, 1'b1, 1'b1, 2'd0, 8'd5);
    idle(2);
    lbl = "done_hold";
    cyc(1'b1, 1'b1, 1'b0, 2'd0, 8'd2);
    idle(4);
    cyc(1'b1, 1'b0, 1'b1, 2'd0, 8'd2);
    idle(2);

    // Full range, then a short restart from DONE.
    lbl = "full255";
    cyc(1'b1, 1'b1, 1'b0, 2'd0, 8'd255);
    idle(260);
    lbl = "restart2";
    cyc(1'b1, 1'b1, 1'b0, 2'd0, 8'd2);
    idle(5);

    // Reset mid-run at count 7.
    lbl = "reset_midrun";
    cyc(1'b1, 1'b1, 1'b0, 2'd2, 8'd200);
    for (int i = 0; i < 200 && m_cnt < 7; i++) idle(1);
    cyc(1'b0, 1'b0, 1'b0, 2'd2, 8'd200);
    idle(3);

    // Randomized commands.
    lbl = "random";
    for (int i = 0; i < 4000; i++) begin
      cyc(($urandom_range(0, 199) != 0),
          ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 15) == 0),
          2'($urandom_range(0, 3)),
          ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 12)));
    end

    repeat (3) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
